// File: rtl/alu_issue_arbiter.sv
// Round-robin issue arbiter sharing one registered ALU between two requesters,
// with a two-stage tag pipe that routes each result back to its issuer.
module alu_issue_arbiter #(
    parameter logic        FIRST_PRIO = 1'b0,
    parameter int unsigned CHECK_OP   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [3:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [3:0]  req1_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_ctrl,
    input  logic [31:0] alu_result,
    output logic        rsp0_valid,
    output logic        rsp1_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err
);

    localparam logic [3:0] OpIdle = 4'b1111;

    logic        last_grant_q, last_grant_d;
    logic [31:0] alu_a_q, alu_a_d;
    logic [31:0] alu_b_q, alu_b_d;
    logic [3:0]  alu_ctrl_q, alu_ctrl_d;
    logic        s1_valid_q, s1_id_q, s1_err_q;
    logic        s1_valid_d, s1_id_d, s1_err_d;
    logic        s2_valid_q, s2_id_q, s2_err_q;

    logic        grant0, grant1;
    logic        issue;
    logic [3:0]  issue_op;
    logic        op_bad;

    // Grant is gated by stall so ready never rises while the pipe is frozen.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!stall) begin
            if (req0_valid && req1_valid) begin
                if (last_grant_q) begin
                    grant0 = 1'b1;
                end else begin
                    grant1 = 1'b1;
                end
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign req0_ready = grant0 & ~stall;
    assign req1_ready = grant1 & ~stall;
    assign issue      = req0_ready | req1_ready;
    assign issue_op   = req1_ready ? req1_op : req0_op;

    always_comb begin
        op_bad = 1'b1;
        unique case (issue_op)
            4'b0000, 4'b0001, 4'b0010, 4'b0110: op_bad = 1'b0;
            default:                            op_bad = 1'b1;
        endcase
    end

    always_comb begin
        last_grant_d = last_grant_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_ctrl_d   = OpIdle;
        s1_valid_d   = 1'b0;
        s1_id_d      = s1_id_q;
        s1_err_d     = 1'b0;
        if (issue) begin
            last_grant_d = req1_ready;
            alu_a_d      = req1_ready ? req1_a : req0_a;
            alu_b_d      = req1_ready ? req1_b : req0_b;
            alu_ctrl_d   = issue_op;
            s1_valid_d   = 1'b1;
            s1_id_d      = req1_ready;
            s1_err_d     = (CHECK_OP != 0) && op_bad;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= ~FIRST_PRIO;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_ctrl_q   <= OpIdle;
            s1_valid_q   <= 1'b0;
            s1_id_q      <= 1'b0;
            s1_err_q     <= 1'b0;
            s2_valid_q   <= 1'b0;
            s2_id_q      <= 1'b0;
            s2_err_q     <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_ctrl_q   <= alu_ctrl_d;
            s1_valid_q   <= s1_valid_d;
            s1_id_q      <= s1_id_d;
            s1_err_q     <= s1_err_d;
            s2_valid_q   <= s1_valid_q;
            s2_id_q      <= s1_id_q;
            s2_err_q     <= s1_err_q;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_ctrl   = alu_ctrl_q;
    // alu_result lines up with s2; stale ALU data is masked by s2_valid_q.
    assign rsp0_valid = s2_valid_q & ~s2_id_q;
    assign rsp1_valid = s2_valid_q & s2_id_q;
    assign rsp_data   = alu_result;
    assign rsp_err    = s2_valid_q & s2_err_q;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Directed bench for alu_issue_arbiter, with a behavioural registered ALU on each
// instance (one with opcode checking, one without).
module tb_alu_issue_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_op, req1_op;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_ctrl;
    logic        rsp0_valid, rsp1_valid, rsp_err;
    logic [31:0] rsp_data;

    logic        n_req0_ready, n_req1_ready;
    logic [31:0] n_alu_a, n_alu_b, n_alu_result;
    logic [3:0]  n_alu_ctrl;
    logic        n_rsp0_valid, n_rsp1_valid, n_rsp_err;
    logic [31:0] n_rsp_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_issue_arbiter #(.FIRST_PRIO(1'b0), .CHECK_OP(1)) u_dut (
        .clk(clk), .reset(reset), .stall(stall),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
        .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    alu_issue_arbiter #(.FIRST_PRIO(1'b0), .CHECK_OP(0)) u_nochk (
        .clk(clk), .reset(reset), .stall(stall),
        .req0_valid(req0_valid), .req0_ready(n_req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(n_req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(n_alu_a), .alu_b(n_alu_b), .alu_ctrl(n_alu_ctrl),
        .alu_result(n_alu_result),
        .rsp0_valid(n_rsp0_valid), .rsp1_valid(n_rsp1_valid),
        .rsp_data(n_rsp_data), .rsp_err(n_rsp_err)
    );

    function automatic logic [31:0] alu_f(logic [31:0] a, logic [31:0] b, logic [3:0] c);
        case (c)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            default: return 32'h0;
        endcase
    endfunction

    // Unreset ALU: starts with garbage so masking by the stage valids is exercised.
    initial begin
        alu_result   = 32'hDEAD_BEEF;
        n_alu_result = 32'hDEAD_BEEF;
    end
    always @(posedge clk) begin
        alu_result   <= alu_f(alu_a, alu_b, alu_ctrl);
        n_alu_result <= alu_f(n_alu_a, n_alu_b, n_alu_ctrl);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req0_op = 4'hF;
        req1_a = '0; req1_b = '0; req1_op = 4'hF;
        stall = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Issue one op on a port, then check the response two edges later.
    task automatic issue_one(input string tag, input bit port, input logic [31:0] a,
                             input logic [31:0] b, input logic [3:0] op,
                             input logic [31:0] exp_data, input logic exp_err);
        if (port) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
        end
        #1;
        check({tag, "_ready"}, {31'd0, port ? req1_ready : req0_ready}, 32'd1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check({tag, "_no_early_rsp"}, {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        tick();
        check({tag, "_rsp_valid"}, {30'd0, rsp1_valid, rsp0_valid}, port ? 32'd2 : 32'd1);
        check({tag, "_data"}, rsp_data, exp_data);
        check({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
        check({tag, "_err_nochk"}, {31'd0, n_rsp_err}, 32'd0);
        tick();
        check({tag, "_pulse_end"}, {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    endtask

    initial begin
        int exp_id;
        idle_inputs();
        reset = 1'b1;
        #2;
        check("async_reset_ctrl", {28'd0, alu_ctrl}, 32'hF);
        tick();
        tick();
        check("reset_alu_a", alu_a, 32'd0);
        check("reset_alu_b", alu_b, 32'd0);
        check("reset_rsp", {29'd0, rsp_err, rsp1_valid, rsp0_valid}, 32'd0);
        reset = 1'b0;
        tick();

        // Reset while an ADD is in flight: dropped, never answered.
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_op = 4'b0010;
        tick();
        req0_valid = 1'b0;
        check("inflight_ctrl", {28'd0, alu_ctrl}, 32'h2);
        #2 reset = 1'b1;
        #1;
        check("midreset_ctrl", {28'd0, alu_ctrl}, 32'hF);
        check("midreset_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("midreset_no_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        end

        issue_one("add_5_7", 1'b0, 32'd5, 32'd7, 4'b0010, 32'd12, 1'b0);

        // Contention from a fresh reset: grants alternate starting with port 0.
        do_reset();
        req0_op = 4'b0010; req1_op = 4'b0010;
        req0_b = 32'd100; req1_b = 32'd200;
        for (int k = 0; k < 8; k++) begin
            req0_valid = (k < 6);
            req1_valid = (k < 6);
            req0_a = k;
            req1_a = k;
            #1;
            if (k < 6) begin
                check("cont_ready", {30'd0, req1_ready, req0_ready},
                      (k % 2 == 0) ? 32'd1 : 32'd2);
            end
            if (k >= 2) begin
                exp_id = (k - 2) % 2;
                check("cont_rsp_id", {30'd0, rsp1_valid, rsp0_valid},
                      (exp_id == 0) ? 32'd1 : 32'd2);
                check("cont_rsp_data", rsp_data,
                      (k - 2) + ((exp_id == 0) ? 32'd100 : 32'd200));
            end else begin
                check("cont_no_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
            end
            tick();
        end
        idle_inputs();
        tick();

        issue_one("sub_3_5", 1'b0, 32'd3, 32'd5, 4'b0110, 32'hFFFF_FFFE, 1'b0);
        issue_one("and", 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'b0000, 32'h00F0_00F0, 1'b0);
        issue_one("or_1_2", 1'b1, 32'd1, 32'd2, 4'b0001, 32'd3, 1'b0);
        issue_one("illegal_op", 1'b1, 32'd9, 32'd9, 4'b0011, 32'd0, 1'b1);

        // Stall right after an issue: no accepts, in-flight result still returns.
        req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd20; req0_op = 4'b0010;
        tick();
        stall = 1'b1;
        req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd1; req1_op = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
            check("stall_rsp0", {31'd0, rsp0_valid}, (i == 1) ? 32'd1 : 32'd0);
            if (i == 1) check("stall_rsp_data", rsp_data, 32'd30);
            tick();
        end
        stall = 1'b0;
        #1;
        check("post_stall_grant1", {30'd0, req1_ready, req0_ready}, 32'd2);
        idle_inputs();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
